// File: rtl/movavg_pkg.sv
// Shared types and helpers for the 2-lane 4-tap moving-sum stream controller.
package movavg_pkg;

    localparam int unsigned W_DEFAULT = 64;

    typedef enum logic {
        FILL_A,
        FILL_B
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_A,
        OUT_B
    } out_state_t;

    // Output state entered after a commit, given how many pairs committed before it.
    // Pair 0 has no complete window; pair 1 has a complete window only in lane B.
    function automatic out_state_t first_lane(input logic suppress, input logic [1:0] pair_cnt);
        out_state_t st;
        st = OUT_A;
        if (suppress) begin
            if (pair_cnt == 2'd0) begin
                st = OUT_IDLE;
            end else if (pair_cnt == 2'd1) begin
                st = OUT_B;
            end
        end
        return st;
    endfunction

endpackage

// File: rtl/movavg_stream_if.sv
// Scalar valid/ready/data stream bundle.
interface movavg_stream_if #(
    parameter int unsigned W = movavg_pkg::W_DEFAULT
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/movavg_pair_core.sv
// Tap history and the two lane adders for one even/odd sample pair.
module movavg_pair_core
    import movavg_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         zero,    // synchronous flush of the history
    input  logic         commit,  // a full pair is being accepted this cycle
    input  logic [W-1:0] a,       // even sample x[2k]
    input  logic [W-1:0] b,       // odd sample x[2k+1]
    output logic [W-1:0] y_a,
    output logic [W-1:0] y_b
);

    logic [W-1:0] h1_q, h2_q, h3_q;
    logic [W-1:0] h1_d, h2_d, h3_d;

    // Sums wrap mod 2^W by construction.
    always_comb begin
        y_a = a + h1_q + h2_q + h3_q;
        y_b = b + a + h1_q + h2_q;
    end

    // History shifts by two samples per commit and never otherwise.
    always_comb begin
        h1_d = h1_q;
        h2_d = h2_q;
        h3_d = h3_q;
        if (zero) begin
            h1_d = '0;
            h2_d = '0;
            h3_d = '0;
        end else if (commit) begin
            h1_d = b;
            h2_d = a;
            h3_d = h1_q;
        end
    end

    // History registers.
    always_ff @(posedge clk) begin
        h1_q <= h1_d;
        h2_q <= h2_d;
        h3_q <= h3_d;
    end

endmodule

// File: rtl/movavg_stream_ctrl.sv
// Pairs input samples, commits pairs into the moving-sum core and serialises both lane
// sums onto the output stream, with warm-up suppression, clear and backpressure.
module movavg_stream_ctrl
    import movavg_pkg::*;
#(
    parameter int unsigned W               = W_DEFAULT,
    parameter int unsigned CW              = 32,
    parameter bit          SUPPRESS_WARMUP = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    movavg_stream_if.slave  s,
    movavg_stream_if.master m,
    output logic          busy,
    output logic [CW-1:0] out_count
);

    in_state_t     in_state_q, in_state_d;
    out_state_t    out_state_q, out_state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  ya_q, ya_d;
    logic [W-1:0]  yb_q, yb_d;
    logic [1:0]    pair_cnt_q, pair_cnt_d;
    logic [CW-1:0] out_count_q, out_count_d;

    logic         flush;
    logic         s_ready;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         s_hs;
    logic         m_hs;
    logic         commit;
    logic [W-1:0] sum_a, sum_b;

    movavg_pair_core #(
        .W (W)
    ) u_core (
        .clk    (clk),
        .zero   (flush),
        .commit (commit),
        .a      (a_q),
        .b      (s.data),
        .y_a    (sum_a),
        .y_b    (sum_b)
    );

    // Handshake decode; lane B may enter while the buffer's last lane is leaving.
    always_comb begin
        flush   = reset | clear;
        s_ready = !flush && ((in_state_q == FILL_A) || (out_state_q == OUT_IDLE) ||
                             ((out_state_q == OUT_B) && m.ready));
        m_valid = (out_state_q != OUT_IDLE);
        m_data  = '0;
        unique case (out_state_q)
            OUT_A:   m_data = ya_q;
            OUT_B:   m_data = yb_q;
            default: m_data = '0;
        endcase
        s_hs    = s.valid && s_ready;
        m_hs    = m_valid && m.ready && !flush;
        commit  = s_hs && (in_state_q == FILL_B);
    end

    assign s.ready   = s_ready;
    assign m.valid   = m_valid;
    assign m.data    = m_data;
    assign busy      = (in_state_q == FILL_B) | m_valid;
    assign out_count = out_count_q;

    // Next state for both FSMs, the pair/output buffers and counters.
    always_comb begin
        in_state_d  = in_state_q;
        out_state_d = out_state_q;
        a_d         = a_q;
        ya_d        = ya_q;
        yb_d        = yb_q;
        pair_cnt_d  = pair_cnt_q;
        out_count_d = out_count_q;
        if (flush) begin
            in_state_d  = FILL_A;
            out_state_d = OUT_IDLE;
            a_d         = '0;
            ya_d        = '0;
            yb_d        = '0;
            pair_cnt_d  = 2'd0;
            out_count_d = '0;
        end else begin
            if (s_hs) begin
                if (in_state_q == FILL_A) begin
                    a_d        = s.data;
                    in_state_d = FILL_B;
                end else begin
                    in_state_d = FILL_A;
                end
            end
            if (m_hs) begin
                out_count_d = out_count_q + CW'(1);
                if (out_state_q == OUT_A) begin
                    out_state_d = OUT_B;
                end else begin
                    out_state_d = OUT_IDLE;
                end
            end
            // A commit only happens with the buffer empty or emptying, so it wins.
            if (commit) begin
                ya_d        = sum_a;
                yb_d        = sum_b;
                out_state_d = first_lane(SUPPRESS_WARMUP, pair_cnt_q);
                if (pair_cnt_q != 2'd2) begin
                    pair_cnt_d = pair_cnt_q + 2'd1;
                end
            end
        end
    end

    // State registers; reset is folded into the next-state logic via flush.
    always_ff @(posedge clk) begin
        in_state_q  <= in_state_d;
        out_state_q <= out_state_d;
        a_q         <= a_d;
        ya_q        <= ya_d;
        yb_q        <= yb_d;
        pair_cnt_q  <= pair_cnt_d;
        out_count_q <= out_count_d;
    end

endmodule

// File: tb/tb_movavg_stream_ctrl.sv
// Directed bench: one instance with warm-up suppression, one without.
module tb_movavg_stream_ctrl;
    import movavg_pkg::*;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr1, clr0;
    logic        busy1, busy0;
    logic [31:0] oc1, oc0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] q1[$];
    logic [63:0] q0[$];

    movavg_stream_if #(.W(64)) s1 ();
    movavg_stream_if #(.W(64)) m1 ();
    movavg_stream_if #(.W(64)) s0 ();
    movavg_stream_if #(.W(64)) m0 ();

    movavg_stream_ctrl #(.W(64), .CW(32), .SUPPRESS_WARMUP(1'b1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr1),
        .s         (s1),
        .m         (m1),
        .busy      (busy1),
        .out_count (oc1)
    );

    movavg_stream_ctrl #(.W(64), .CW(32), .SUPPRESS_WARMUP(1'b0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr0),
        .s         (s0),
        .m         (m0),
        .busy      (busy0),
        .out_count (oc0)
    );

    always #5 clk = ~clk;

    // Record every output transfer in order.
    always @(posedge clk) begin
        if (!reset && !clr1 && m1.valid && m1.ready) q1.push_back(m1.data);
        if (!reset && !clr0 && m0.valid && m0.ready) q0.push_back(m0.data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; clr1 = 1'b0; clr0 = 1'b0;
        s1.valid = 1'b1; s1.data = '0; m1.ready = 1'b1;
        s0.valid = 1'b0; s0.data = '0; m0.ready = 1'b1;

        // Reset state
        nx(); #1;
        chk("rst_s_ready", 64'(s1.ready), 64'd0);
        chk("rst_m_valid", 64'(m1.valid), 64'd0);
        chk("rst_m_data", m1.data, 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_out_count", 64'(oc1), 64'd0);
        chk("rst_m_valid0", 64'(m0.valid), 64'd0);
        reset = 1'b0; s1.valid = 1'b0;

        // Test 1: suppression, back-to-back 1..6
        nx(); s1.valid = 1'b1; s1.data = 64'd1; #1;
        chk("t1_s_ready_fill_a", 64'(s1.ready), 64'd1);
        nx(); s1.data = 64'd2;
        nx();
        chk("t1_pair0_dropped", 64'(m1.valid), 64'd0);
        chk("t1_busy_fill_a", 64'(busy1), 64'd0);
        s1.data = 64'd3;
        nx();
        chk("t1_busy_fill_b", 64'(busy1), 64'd1);
        s1.data = 64'd4;
        nx();
        chk("t1_latency_valid", 64'(m1.valid), 64'd1);
        chk("t1_latency_data", m1.data, 64'd10);
        s1.data = 64'd5;
        nx(); s1.data = 64'd6; #1;
        chk("t1_s_ready_fill_b", 64'(s1.ready), 64'd1);
        nx(); s1.valid = 1'b0;
        chk("t1_y4", m1.data, 64'd14);
        nx();
        chk("t1_y5", m1.data, 64'd18);
        nx();
        chk("t1_idle", 64'(m1.valid), 64'd0);
        chk("t1_out_count", 64'(oc1), 64'd3);
        chk("t1_q_size", 64'(q1.size()), 64'd3);
        chk("t1_q0", q1[0], 64'd10);
        chk("t1_q1", q1[1], 64'd14);
        chk("t1_q2", q1[2], 64'd18);
        q1.delete();

        // Test 5: clear with A held and lane B pending under a live m handshake
        nx(); s1.valid = 1'b1; s1.data = 64'd1;
        nx(); s1.data = 64'd2;
        nx();
        chk("t5_ya", m1.data, 64'd16);
        s1.data = 64'd3;
        nx();
        chk("t5_yb_pending", m1.data, 64'd14);
        clr1 = 1'b1; s1.data = 64'd99; #1;
        chk("t5_clear_s_ready", 64'(s1.ready), 64'd0);
        nx(); clr1 = 1'b0; s1.valid = 1'b0;
        chk("t5_clear_m_valid", 64'(m1.valid), 64'd0);
        chk("t5_clear_m_data", m1.data, 64'd0);
        chk("t5_clear_busy", 64'(busy1), 64'd0);
        chk("t5_clear_count", 64'(oc1), 64'd0);
        chk("t5_q_pre_size", 64'(q1.size()), 64'd1);
        chk("t5_q_pre0", q1[0], 64'd16);
        q1.delete();
        nx(); s1.valid = 1'b1; s1.data = 64'd10;
        nx(); s1.data = 64'd20;
        nx(); s1.data = 64'd30;
        nx(); s1.data = 64'd40;
        nx(); s1.valid = 1'b0;
        chk("t5_y3_data", m1.data, 64'd100);
        nx(); nx();
        chk("t5_out_count", 64'(oc1), 64'd1);
        chk("t5_q_size", 64'(q1.size()), 64'd1);
        chk("t5_q0", q1[0], 64'd100);
        q1.delete();

        // Test 2: no suppression
        nx(); s0.valid = 1'b1; s0.data = 64'd5;
        nx(); s0.data = 64'd6;
        nx();
        chk("t2_latency_data", m0.data, 64'd5);
        s0.data = 64'd7;
        nx(); s0.data = 64'd8; #1;
        chk("t2_s_ready_out_b", 64'(s0.ready), 64'd1);
        nx(); s0.valid = 1'b0;
        nx(); nx();
        chk("t2_out_count", 64'(oc0), 64'd4);
        chk("t2_q_size", 64'(q0.size()), 64'd4);
        chk("t2_q0", q0[0], 64'd5);
        chk("t2_q1", q0[1], 64'd11);
        chk("t2_q2", q0[2], 64'd18);
        chk("t2_q3", q0[3], 64'd26);
        q0.delete();

        // Test 4: backpressure on lane B stalls the next pair
        nx(); s0.valid = 1'b1; s0.data = 64'd1;
        nx(); s0.data = 64'd2;
        nx();
        chk("t4_ya", m0.data, 64'd22);
        s0.data = 64'd3;
        nx(); m0.ready = 1'b0;
        chk("t4_yb", m0.data, 64'd18);
        s0.data = 64'd4; #1;
        chk("t4_s_ready_blocked", 64'(s0.ready), 64'd0);
        nx();
        chk("t4_hold_valid", 64'(m0.valid), 64'd1);
        chk("t4_hold_data", m0.data, 64'd18);
        chk("t4_busy", 64'(busy0), 64'd1);
        #1;
        chk("t4_s_ready_still_blocked", 64'(s0.ready), 64'd0);
        nx(); m0.ready = 1'b1; #1;
        chk("t4_s_ready_release", 64'(s0.ready), 64'd1);
        nx(); s0.valid = 1'b0;
        chk("t4_ya2", m0.data, 64'd14);
        nx();
        chk("t4_yb2", m0.data, 64'd10);
        nx();
        chk("t4_idle", 64'(m0.valid), 64'd0);
        chk("t4_out_count", 64'(oc0), 64'd8);
        chk("t4_q_size", 64'(q0.size()), 64'd4);
        chk("t4_q0", q0[0], 64'd22);
        chk("t4_q1", q0[1], 64'd18);
        chk("t4_q2", q0[2], 64'd14);
        chk("t4_q3", q0[3], 64'd10);
        q0.delete();

        // Test 3: modular wrap
        nx(); clr0 = 1'b1;
        nx(); clr0 = 1'b0;
        chk("t3_clear_count", 64'(oc0), 64'd0);
        s0.valid = 1'b1; s0.data = ONES;
        nx(); nx(); nx();
        nx(); s0.valid = 1'b0;
        nx(); nx(); nx();
        chk("t3_q_size", 64'(q0.size()), 64'd4);
        chk("t3_y0", q0[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_y1", q0[1], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t3_y2", q0[2], 64'hFFFF_FFFF_FFFF_FFFD);
        chk("t3_y3", q0[3], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t3_out_count", 64'(oc0), 64'd4);
        q0.delete();

        // Test 6: reset while lane A is pending and stalled
        m0.ready = 1'b0;
        nx(); s0.valid = 1'b1; s0.data = 64'd1;
        nx(); s0.data = 64'd2;
        nx(); s0.valid = 1'b0;
        chk("t6_pending", 64'(m0.valid), 64'd1);
        reset = 1'b1;
        nx();
        chk("t6_rst_m_valid", 64'(m0.valid), 64'd0);
        chk("t6_rst_m_data", m0.data, 64'd0);
        chk("t6_rst_count", 64'(oc0), 64'd0);
        chk("t6_rst_busy", 64'(busy0), 64'd0);
        reset = 1'b0;
        nx();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
